// File: rtl/osc_timebase.sv
// Oscillator-domain timebase: reset sequencer, fractional 1 us / 1 ms strobes,
// free-running millisecond uptime counter and a one-shot millisecond timer.
module osc_timebase #(
  parameter int unsigned CLK_HZ     = 125000000,
  parameter int unsigned TICK_HZ    = 1000000,
  parameter int unsigned MS_DIV     = 1000,
  parameter int unsigned POR_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rst_out_n,
  output logic        tick_us,
  output logic        tick_ms,
  output logic [31:0] uptime_ms,
  input  logic        timer_start,
  input  logic [15:0] timer_ms,
  output logic        timer_busy,
  output logic        timer_done
);

  localparam int unsigned ACC_W = $clog2(CLK_HZ) + 1;
  localparam int unsigned POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam int unsigned US_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  localparam logic [ACC_W-1:0] CLK_V    = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] TICK_V   = ACC_W'(TICK_HZ);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(MS_DIV - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  logic [1:0]       sync_q,    sync_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;
  logic             rst_out_q, rst_out_d;

  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [ACC_W-1:0] acc_sum;
  logic             tick_us_q, tick_us_d;
  logic [US_W-1:0]  us_cnt_q,  us_cnt_d;
  logic             tick_ms_q, tick_ms_d;
  logic [31:0]      uptime_q,  uptime_d;

  state_t           state_q,   state_d;
  logic [15:0]      rem_q,     rem_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  // The POR count only starts once the synchronizer output is high, so the
  // stretched release lands POR_CYCLES+2 edges after rst_n rises.
  always_comb begin
    sync_d    = {sync_q[0], 1'b1};
    por_cnt_d = por_cnt_q;
    rst_out_d = rst_out_q;
    if (sync_q[1] && !rst_out_q) begin
      if (por_cnt_q == POR_LAST) begin
        rst_out_d = 1'b1;
      end else begin
        por_cnt_d = por_cnt_q + POR_W'(1);
      end
    end
  end

  always_comb begin
    acc_sum   = acc_q + TICK_V;
    acc_d     = acc_q;
    tick_us_d = 1'b0;
    us_cnt_d  = us_cnt_q;
    tick_ms_d = 1'b0;
    uptime_d  = uptime_q;
    if (rst_out_q) begin
      if (acc_sum >= CLK_V) begin
        acc_d     = acc_sum - CLK_V;
        tick_us_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
      if (tick_us_d) begin
        if (us_cnt_q == US_LAST) begin
          us_cnt_d  = '0;
          tick_ms_d = 1'b1;
        end else begin
          us_cnt_d = us_cnt_q + US_W'(1);
        end
      end
      if (tick_ms_d) begin
        uptime_d = uptime_q + 32'd1;
      end
    end
  end

  // A start request always takes priority over a coinciding expiry.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (rst_out_q) begin
      if (timer_start) begin
        if (timer_ms == '0) begin
          state_d = IDLE;
          rem_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
          rem_d   = timer_ms;
          busy_d  = 1'b1;
        end
      end else if (state_q == RUN && tick_ms_q) begin
        if (rem_q == 16'd1) begin
          state_d = IDLE;
          rem_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      por_cnt_q <= '0;
      rst_out_q <= 1'b0;
      acc_q     <= '0;
      tick_us_q <= 1'b0;
      us_cnt_q  <= '0;
      tick_ms_q <= 1'b0;
      uptime_q  <= '0;
      state_q   <= IDLE;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      por_cnt_q <= por_cnt_d;
      rst_out_q <= rst_out_d;
      acc_q     <= acc_d;
      tick_us_q <= tick_us_d;
      us_cnt_q  <= us_cnt_d;
      tick_ms_q <= tick_ms_d;
      uptime_q  <= uptime_d;
      state_q   <= state_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rst_out_n  = rst_out_q;
  assign tick_us    = tick_us_q;
  assign tick_ms    = tick_ms_q;
  assign uptime_ms  = uptime_q;
  assign timer_busy = busy_q;
  assign timer_done = done_q;

endmodule
